// File: rtl/la_txdiff_ser.sv
// Purpose : serialize valid/ready parallel words LSB-first into start/data/stop frames for a differential TX pad.
// Latency : start bit (ap=0) appears the cycle after the accepting edge; each bit lasts DIV cycles.
// Backpr. : in_ready only in IDLE or the last STOP cycle (back-to-back frames); words offered while busy are ignored.
//
// Ports:
//   clk       core clock, rising edge
//   nreset    synchronous active-low reset
//   en        transmitter enable (also drives the pad output enable)
//   in_valid  word valid
//   in_data   DW-bit word to send
//   in_ready  word accepted on this edge if in_valid is also high
//   ap / an   complementary serial line to the pad cell (idle = mark, ap=1)
//   oe        registered pad output enable
//   busy      frame in progress
//
// Optional feature: define LA_TXDIFF_SER_PARITY_EN to append an even-parity
// bit (PAR state) between the last data bit and the stop bit.
module la_txdiff_ser #(
    parameter     PROP = "DEFAULT",
    parameter int DW   = 8,
    parameter int DIV  = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          ap,
    output logic          an,
    output logic          oe,
    output logic          busy
);

    localparam int BCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(DW + 1);

    localparam logic [BCW-1:0] CNT_LAST = BCW'(DIV - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(DW - 1);

`ifdef LA_TXDIFF_SER_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t           r_state;
    logic [BCW-1:0]   r_bitcnt;
    logic [IW-1:0]    r_idx;
    logic [DW-1:0]    r_shreg;
    logic             r_ap;
    logic             r_oe;

    state_t           w_state_nxt;
    logic [BCW-1:0]   w_bitcnt_nxt;
    logic [IW-1:0]    w_idx_nxt;
    logic [DW-1:0]    w_shreg_nxt;
    logic             w_ap_nxt;
    logic             w_last;
    logic             w_xfer;

`ifdef LA_TXDIFF_SER_PARITY_EN
    logic             r_par;
    logic             w_par_nxt;
`endif

    // Last cycle of the current bit time; with DIV=1 this is always true.
    assign w_last   = (r_bitcnt == CNT_LAST);

    // Accepting in the last STOP cycle lets the next start bit follow with no idle gap.
    assign in_ready = en & nreset & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_last));
    assign w_xfer   = in_valid & in_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = w_last ? '0 : r_bitcnt + 1'b1;
        w_idx_nxt    = r_idx;
        w_shreg_nxt  = r_shreg;
`ifdef LA_TXDIFF_SER_PARITY_EN
        w_par_nxt    = r_par;
`endif
        if (w_xfer) begin
            w_state_nxt  = S_START;
            w_bitcnt_nxt = '0;
            w_idx_nxt    = '0;
            w_shreg_nxt  = in_data;
`ifdef LA_TXDIFF_SER_PARITY_EN
            w_par_nxt    = ^in_data;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_bitcnt_nxt = '0;
                end
                S_START: begin
                    if (w_last) begin
                        w_state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_last) begin
                        w_shreg_nxt = r_shreg >> 1;
                        w_idx_nxt   = r_idx + 1'b1;
                        if (r_idx == IDX_LAST) begin
`ifdef LA_TXDIFF_SER_PARITY_EN
                            w_state_nxt = S_PAR;
`else
                            w_state_nxt = S_STOP;
`endif
                        end
                    end
                end
`ifdef LA_TXDIFF_SER_PARITY_EN
                S_PAR: begin
                    if (w_last) begin
                        w_state_nxt = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_bitcnt_nxt = '0;
                end
            endcase
        end
    end

    // Line value is registered from the next state so ap changes exactly
    // on the edge that enters each bit; shreg[0] is the bit about to go out.
    always_comb begin
        w_ap_nxt = 1'b1;
        case (w_state_nxt)
            S_START: w_ap_nxt = 1'b0;
            S_DATA:  w_ap_nxt = w_shreg_nxt[0];
`ifdef LA_TXDIFF_SER_PARITY_EN
            S_PAR:   w_ap_nxt = w_par_nxt;
`endif
            default: w_ap_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_idx    <= '0;
            r_shreg  <= '0;
            r_ap     <= 1'b1;
            r_oe     <= 1'b0;
`ifdef LA_TXDIFF_SER_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_idx    <= w_idx_nxt;
            r_shreg  <= w_shreg_nxt;
            r_ap     <= w_ap_nxt;
`ifdef LA_TXDIFF_SER_PARITY_EN
            r_par    <= w_par_nxt;
`endif
            // Driver stays enabled until any frame in flight has drained.
            if (en) begin
                r_oe <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_oe <= 1'b0;
            end
        end
    end

    assign ap   = r_ap;
    assign an   = ~r_ap;
    assign oe   = r_oe;
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_la_txdiff_ser.sv
`timescale 1ns/1ps
module tb_la_txdiff_ser;

    localparam int DW  = 8;
    localparam int DIV = 4;
`ifdef LA_TXDIFF_SER_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int FLEN = NBITS * DIV;
    localparam int LIM  = 4 * FLEN;

    logic          clk      = 1'b0;
    logic          nreset   = 1'b0;
    logic          en       = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready;
    logic          ap;
    logic          an;
    logic          oe;
    logic          busy;

    always #5 clk = ~clk;

    la_txdiff_ser #(
        .PROP ("DEFAULT"),
        .DW   (DW),
        .DIV  (DIV)
    ) dut (
        .clk      (clk),
        .nreset   (nreset),
        .en       (en),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ap       (ap),
        .an       (an),
        .oe       (oe),
        .busy     (busy)
    );

    int   compared   = 0;
    int   mismatched = 0;
    logic exp_q[$];          // expected ap, one entry per cycle of frames in flight
    int   acc_cnt    = 0;    // words the reference model says were accepted
    bit   mon_on     = 1'b0;
    logic oe_exp     = 1'b0;
    int   busy_run   = 0;
    int   last_run   = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference waveform of one frame: start, LSB-first data, [parity], stop.
    function automatic void push_frame(input logic [DW-1:0] d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
`ifdef LA_TXDIFF_SER_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k < DIV; k++) exp_q.push_back(bits[i]);
        end
    endfunction

    // Monitor: each cycle pops the expected line value and compares all outputs.
    always @(negedge clk) begin
        logic e_rdy;
        logic e_ap;
        logic e_busy;
        logic was_idle;
        if (mon_on) begin
            was_idle = (exp_q.size() == 0);
            e_rdy    = en && nreset && (exp_q.size() <= 1);
            chk1("in_ready", in_ready, e_rdy);
            if (was_idle) begin
                e_ap   = 1'b1;
                e_busy = 1'b0;
            end else begin
                e_ap   = exp_q.pop_front();
                e_busy = 1'b1;
            end
            chk1("ap", ap, e_ap);
            chk1("an", an, ~e_ap);
            chk1("busy", busy, e_busy);
            chk1("oe", oe, oe_exp);

            if (busy) busy_run++;
            else begin
                if (busy_run > 0) last_run = busy_run;
                busy_run = 0;
            end

            if (!nreset) begin
                exp_q.delete();
            end else if (in_valid && e_rdy) begin
                push_frame(in_data);
                acc_cnt++;
            end

            if (!nreset)       oe_exp = 1'b0;
            else if (en)       oe_exp = 1'b1;
            else if (was_idle) oe_exp = 1'b0;
        end
    end

    task automatic send(input logic [DW-1:0] d, input bit hold);
        int n0;
        int t;
        n0       = acc_cnt;
        t        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (acc_cnt == n0 && t < LIM) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (acc_cnt == n0) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: word %0h not accepted within %0d cycles", d, LIM);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < LIM) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL idle_timeout: frame still pending after %0d cycles", LIM);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        nreset = 1'b0;
        en     = 1'b1;
        @(posedge clk);
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_ready", in_ready, 1'b0);
        chk1("reset_oe", oe, 1'b0);
        nreset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("release_oe", oe, 1'b1);
        chk1("release_ready", in_ready, 1'b1);

        // Single frame
        send(8'hA5, 1'b0);
        wait_idle();
        chkn("frame_len_a5", last_run, FLEN);

        // Back-to-back with in_valid held
        send(8'h00, 1'b1);
        send(8'hFF, 1'b0);
        wait_idle();
        chkn("frame_len_b2b", last_run, 2 * FLEN);

        // en dropped during data bit 3; pending word must not be taken
        send(8'h5A, 1'b0);
        repeat (4 * DIV) @(posedge clk);
        #1;
        en       = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        n0       = acc_cnt;
        repeat (FLEN + 4) @(posedge clk);
        #1;
        chkn("no_accept_en_low", acc_cnt, n0);
        chkn("frame_len_en_drop", last_run, FLEN);
        chk1("oe_off_idle", oe, 1'b0);
        in_valid = 1'b0;
        en       = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset during data bit 5
        send(8'h96, 1'b0);
        repeat (6 * DIV) @(posedge clk);
        #1;
        nreset = 1'b0;
        @(posedge clk);
        #1;
        chk1("abort_ap", ap, 1'b1);
        chk1("abort_busy", busy, 1'b0);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        send(8'h3C, 1'b0);
        wait_idle();
        chkn("frame_len_3c", last_run, FLEN);

        // Randomized traffic with idle gaps and occasional back-to-back holds
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(DW'($urandom), ($urandom_range(0, 1) == 1));
        end
        in_valid = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/la_txdiff_ser.md
# la_txdiff_ser

Digital differential serial transmitter front end. It accepts parallel words over a valid/ready handshake and serializes each word LSB-first into a start/data/stop frame. The serial output drives the complementary core-side inputs of a differential TX pad cell. It sits between core logic and the pad ring, and is the transmit counterpart of the differential receive IO path.

## Interface

Parameters:
- PROP, "DEFAULT": cell property string, passed through for library selection; no functional effect.
- DW, 8: data word width (1–32).
- DIV, 4: clock cycles per serial bit (1–65535).

Ports:
- clk  input  1  core clock; all logic on the rising edge.
- nreset  input  1  synchronous active-low reset; one clock, sampled on the rising edge.
- en  input  1  transmitter enable.
- in_valid  input  1  word valid.
- in_data  input  DW  word to send.
- in_ready  output  1  block can accept a word this cycle.
- ap  output  1  positive serial output to pad cell.
- an  output  1  negative serial output to pad cell; always the inverse of ap.
- oe  output  1  pad output enable.
- busy  output  1  a frame is in progress.

## Operation

- States:
  - IDLE: line at mark, ap=1.
  - START: one bit time, ap=0.
  - DATA: DW bits, LSB first.
  - PAR: only with the parity macro.
  - STOP: one bit time, ap=1.
- Each bit is held for exactly DIV cycles.
  - A bit counter (width clog2(DIV), minimum 1) counts 0..DIV-1.
  - A bit index counter (width clog2(DW+1)) counts data bits.
- Handshake and frame start:
  - A transfer occurs on a rising edge with in_valid & in_ready.
  - in_data is captured into a DW-bit shift register.
  - The next state is START.
- in_ready is combinational: en & nreset & ((state==IDLE) | (state==STOP & last cycle of stop bit)).
  - This allows back-to-back frames with no idle gap.
  - A transfer in the last STOP cycle goes directly to START.
- DATA sends shreg[0] each bit time, then shifts right. After bit DW-1 the next state is STOP, or PAR when the parity macro is defined.
- Stop-bit completion: at the last STOP cycle with no transfer, the next state is IDLE.
- busy=1 in every state except IDLE.
- oe:
  - Registered.
  - Set on the cycle after en is sampled high.
  - Cleared only when en is low and state is IDLE.
- Deasserting en mid-frame:
  - The current frame completes.
  - in_ready drops immediately.
  - oe falls one cycle after the return to IDLE.
- in_data and in_valid changes while busy are ignored.
- an = ~ap at all times, both registered from the same flop source.

## Timing

- Reset values (nreset low at an edge):
  - state=IDLE, ap=1, an=0, oe=0, busy=0.
  - Counters and shift register cleared.
  - in_ready=0 while nreset is low.
- Reset mid-frame: the frame is aborted and the line returns to mark on the next edge. No partial stop bit is sent.
- Latency: ap falls (start bit) on the cycle after the accepting edge, i.e. one cycle after the handshake.
- Frame length: (DW+2)*DIV cycles, or (DW+3)*DIV with parity.
  - Back-to-back throughput is one word per frame length.
- DIV=1: every state lasts one cycle. The STOP cycle is also its last cycle, so in_ready is high there.
- Simultaneous en fall and handshake in the same cycle: en is sampled low, so in_ready is 0 and there is no transfer.

## Configuration

- LA_TXDIFF_SER_PARITY_EN:
  - Defined: a PAR state follows DATA and sends the even parity bit (^ of the captured word) for DIV cycles. The parity bit is computed at capture.
  - Undefined: there is no PAR state and no parity logic; DATA goes straight to STOP.

## Test plan

- Reset and idle:
  - Hold nreset low 3 cycles with en=1 → ap=1, an=0, oe=0, busy=0, in_ready=0.
  - Release → oe=1 after one cycle, in_ready=1.
- Single frame, DW=8, DIV=4: send 0xA5 → ap sequence 0, 1,0,1,0,0,1,0,1, 1, each held exactly 4 cycles. busy high for 40 cycles. an=~ap every cycle.
- Back-to-back: keep in_valid=1 with 0x00 then 0xFF → second start bit begins immediately after cycle 40 with no idle cycle. Total 80 busy cycles.
- en drop mid-frame: deassert en at data bit 3 →
  - Frame completes unchanged.
  - in_ready=0 at once.
  - oe=0 one cycle after IDLE.
  - A pending in_valid is not accepted.
- Reset mid-frame: assert nreset at data bit 5 → next cycle ap=1, busy=0. After release, a new word 0x3C frames correctly.
- Parity build with the macro defined, DIV=1:
  - 0x07 → parity bit 1, frame length 11 cycles.
  - 0x03 → parity bit 0.
  - Without the macro, frame length is 10 cycles.
